// File: rtl/cache_defs_pkg.sv
// Shared cache subsystem definitions: line width and memory-arbiter state encoding.
package cache_defs;

  localparam int ARB_LINE_WIDTH = 128;
  localparam int ARB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BUSY  = 2'd1,
    DC_BUSY  = 2'd2,
    IC_DRAIN = 2'd3
  } type_arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache refills and dcache refills/writebacks onto one non-abortable memory bus.
// One grant per IDLE visit, round-robin on ties; bus outputs registered at grant, acks combinational from mem_ack.
module cache_mem_arbiter
  import cache_defs::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ic_req,
  input  logic [ARB_ADDR_WIDTH-1:0] ic_addr,
  input  logic                      ic_kill,
  output logic                      ic_ack,
  output logic [ARB_LINE_WIDTH-1:0] ic_rdata,
  input  logic                      dc_req,
  input  logic                      dc_w_en,
  input  logic [ARB_ADDR_WIDTH-1:0] dc_addr,
  input  logic [ARB_LINE_WIDTH-1:0] dc_wdata,
  output logic                      dc_ack,
  output logic [ARB_LINE_WIDTH-1:0] dc_rdata,
  output logic                      mem_req,
  output logic                      mem_w_en,
  output logic [ARB_ADDR_WIDTH-1:0] mem_addr,
  output logic [ARB_LINE_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [ARB_LINE_WIDTH-1:0] mem_rdata
);

  type_arb_state_e state, state_nxt;
  logic            last_dc;
  logic            ic_ok;
  logic            grant_ic;
  logic            grant_dc;

  // A refill killed in the same cycle it is requested is never granted.
  assign ic_ok = ic_req & ~ic_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_dc <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_ic || grant_dc) begin
        last_dc <= grant_dc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_ic  = 1'b0;
    grant_dc  = 1'b0;
    ic_ack    = 1'b0;
    dc_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (ic_ok && dc_req) begin
          grant_ic = last_dc;
          grant_dc = ~last_dc;
        end else begin
          grant_ic = ic_ok;
          grant_dc = dc_req & ~ic_ok;
        end
        if (grant_ic) begin
          state_nxt = IC_BUSY;
        end else if (grant_dc) begin
          state_nxt = DC_BUSY;
        end
      end
      IC_BUSY: begin
        ic_ack = mem_ack;
        if (mem_ack) begin
          state_nxt = IDLE;
        end else if (ic_kill) begin
          state_nxt = IC_DRAIN;
        end
      end
      DC_BUSY: begin
        dc_ack = mem_ack;
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      IC_DRAIN: begin
        // Bus cannot be aborted: wait out the access and swallow its ack.
        if (mem_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_ic) begin
      mem_req   <= 1'b1;
      mem_w_en  <= 1'b0;
      mem_addr  <= ic_addr;
      mem_wdata <= '0;
    end else if (grant_dc) begin
      mem_req   <= 1'b1;
      mem_w_en  <= dc_w_en;
      mem_addr  <= dc_addr;
      mem_wdata <= dc_wdata;
    end else if (state != IDLE && mem_ack) begin
      mem_req <= 1'b0;
    end
  end

  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and random checks of cache_mem_arbiter against a transaction-level owner model.
module tb_cache_mem_arbiter;
  import cache_defs::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, ic_kill, ic_ack;
  logic [31:0]  ic_addr;
  logic [127:0] ic_rdata;
  logic         dc_req, dc_w_en, dc_ack;
  logic [31:0]  dc_addr;
  logic [127:0] dc_wdata, dc_rdata;
  logic         mem_req, mem_w_en, mem_ack;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_kill(ic_kill), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_w_en(dc_w_en), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: who owns the bus (0 none, 1 icache, 2 dcache), whether the icache owner was killed,
  // who won the last grant, and what was latched onto the bus.
  int           owner = 0;
  bit           killed = 0;
  bit           last_was_dc = 0;
  logic [31:0]  e_addr = '0;
  logic         e_wen = 1'b0;
  logic [127:0] e_wdata = '0;
  int           glog[$];
  int           gcyc[$];
  int           cyc = 0;
  int           wait_cnt = 0;
  int           n_ic_ack = 0;
  int           n_dc_ack = 0;
  bit           seen_ic_ack = 0;
  bit           seen_dc_ack = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int pick;
    bit want_ic;
    if (!rst_n) begin
      owner = 0; killed = 0; last_was_dc = 0;
    end else if (owner == 0) begin
      want_ic = ic_req && !ic_kill;
      if (want_ic && dc_req) pick = last_was_dc ? 1 : 2;
      else if (want_ic)      pick = 1;
      else if (dc_req)       pick = 2;
      else                   pick = 0;
      if (pick != 0) begin
        owner = pick;
        last_was_dc = (pick == 2);
        e_addr  = (pick == 1) ? ic_addr : dc_addr;
        e_wen   = (pick == 1) ? 1'b0 : dc_w_en;
        e_wdata = dc_wdata;
        glog.push_back(pick);
        gcyc.push_back(cyc);
      end
    end else if (mem_ack) begin
      owner = 0; killed = 0;
    end else if (owner == 1 && ic_kill) begin
      killed = 1;
    end
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+3, then the model advances on the edge.
  task automatic step();
    bit e_ic, e_dc;
    #2;
    e_ic = rst_n && owner == 1 && !killed && mem_ack;
    e_dc = rst_n && owner == 2 && mem_ack;
    chk("mem_req", mem_req, owner != 0);
    chk("ic_ack", ic_ack, e_ic);
    chk("dc_ack", dc_ack, e_dc);
    if (e_ic) chk("ic_rdata", ic_rdata, mem_rdata);
    if (e_dc) chk("dc_rdata", dc_rdata, mem_rdata);
    if (owner != 0) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_w_en", mem_w_en, e_wen);
      if (owner == 2) chk("mem_wdata", mem_wdata, e_wdata);
    end
    if (ic_ack === 1'b1) n_ic_ack++;
    if (dc_ack === 1'b1) n_dc_ack++;
    seen_ic_ack = e_ic;
    seen_dc_ack = e_dc;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic mem_drive(input int lat);
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (mem_req && !mem_ack) begin
      if (wait_cnt >= lat) begin
        mem_ack = 1'b1; wait_cnt = 0;
      end else begin
        mem_ack = 1'b0; wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0; wait_cnt = 0;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ic_req = 0; ic_kill = 0; ic_addr = '0;
    dc_req = 0; dc_w_en = 0; dc_addr = '0; dc_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_w_en", mem_w_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tie after reset, then held ties: dcache, icache, dcache with one IDLE cycle between.
    ic_req = 1; ic_addr = 32'h0000_1000;
    dc_req = 1; dc_w_en = 0; dc_addr = 32'h0000_2000; dc_wdata = 128'h5;
    n = 0;
    while ((glog.size() < 3 || owner != 0) && n < 40) begin
      mem_drive(0);
      step();
      n++;
    end
    ic_req = 0; dc_req = 0; mem_ack = 0;
    chk("tie_grants", glog.size(), 3);
    if (glog.size() >= 3) begin
      chk("tie_first_dc", glog[0], 2);
      chk("tie_second_ic", glog[1], 1);
      chk("tie_third_dc", glog[2], 2);
      chk("tie_gap", gcyc[1] - gcyc[0], 2);
    end
    step();

    // Single icache refill, memory acks 3 cycles after mem_req.
    ic_req = 1; ic_addr = 32'h8000_0040; n_ic_ack = 0; n_dc_ack = 0;
    step();
    chk("ic_single_req", mem_req, 1'b1);
    chk("ic_single_wen", mem_w_en, 1'b0);
    chk("ic_single_addr", mem_addr, 32'h8000_0040);
    n = 0;
    while (owner != 0 && n < 10) begin
      mem_drive(3);
      step();
      if (seen_ic_ack) ic_req = 0;
      n++;
    end
    chk("ic_single_cycles", n, 4);
    chk("ic_single_acks", n_ic_ack, 1);
    chk("ic_single_no_dc", n_dc_ack, 0);
    mem_ack = 0; ic_req = 0;
    step();

    // Dcache writeback.
    dc_req = 1; dc_w_en = 1; dc_addr = 32'h0000_3FC0;
    dc_wdata = 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D;
    n_dc_ack = 0;
    step();
    chk("wb_wen", mem_w_en, 1'b1);
    chk("wb_wdata", mem_wdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_FEED_F00D);
    n = 0;
    while (owner != 0 && n < 10) begin
      mem_drive(2);
      step();
      if (seen_dc_ack) dc_req = 0;
      n++;
    end
    chk("wb_acks", n_dc_ack, 1);
    mem_ack = 0; dc_req = 0; dc_w_en = 0;
    step();

    // Kill during refill: kill at cycle 2, mem_ack at cycle 5.
    n_ic_ack = 0;
    ic_req = 1; ic_addr = 32'h0000_4000;
    step();                               // cycle 0
    step();                               // cycle 1
    ic_kill = 1; step();                  // cycle 2
    ic_kill = 0; ic_req = 0; step();      // cycle 3
    chk("kill_req_held", mem_req, 1'b1);
    step();                               // cycle 4
    mem_ack = 1; step();                  // cycle 5
    mem_ack = 0;
    chk("kill_req_drop", mem_req, 1'b0);
    chk("kill_no_ack", n_ic_ack, 0);
    step();                               // cycle 6

    // Kill coincident with mem_ack still delivers the ack.
    ic_req = 1; ic_addr = 32'h0000_5000; n_ic_ack = 0;
    step();
    ic_kill = 1; mem_ack = 1; mem_rdata = 128'hA5A5;
    step();
    ic_kill = 0; mem_ack = 0; ic_req = 0;
    chk("kill_ack_same", n_ic_ack, 1);
    step();

    // Reset while DC_BUSY; a later mem_ack must not produce an ack.
    dc_req = 1; dc_w_en = 1; dc_addr = 32'h0000_6000; dc_wdata = 128'h77;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_dc_ack", dc_ack, 1'b0);
    model_update();
    @(posedge clk);
    #1;
    rst_n = 1'b1; dc_req = 0; n_dc_ack = 0;
    mem_ack = 1;
    step();
    mem_ack = 0;
    step();
    chk("rst_mid_no_ack", n_dc_ack, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      if (seen_ic_ack || ic_kill) ic_req = 0;
      ic_kill = ($urandom_range(0, 11) == 0);
      if (!ic_req && $urandom_range(0, 2) == 0) begin
        ic_req = 1;
        ic_addr = $urandom & 32'hFFFF_FFF0;
      end
      if (seen_dc_ack) dc_req = 0;
      if (!dc_req && $urandom_range(0, 2) == 0) begin
        dc_req = 1;
        dc_w_en = $urandom_range(0, 1);
        dc_addr = $urandom & 32'hFFFF_FFF0;
        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem_req) begin
        mem_drive($urandom_range(0, 4));
      end else begin
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_ack = ($urandom_range(0, 7) == 0);
        wait_cnt = 0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
